// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver with a one-deep holding register.
//
// Consumes an already-synchronized, glitch-filtered serial line. A 1->0 edge
// on rxd starts a frame. The start bit is re-checked at mid-bit, and the eight
// data bits (LSB first) and the stop bit are sampled at mid-bit using a
// runtime bit-period divisor. Each completed frame is offered to a one-entry
// holding register. The register carries full / framing-error / overrun
// status that the consumer acknowledges with a one-cycle rd pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rxd        serial data in, idle high
//   bitperiod  clocks per bit (P), latched at start detection, clamped to >= 4
//   rd         one-cycle acknowledge: clears full, ferr and ovr
//   data       held byte
//   full       holding register contains an unread byte
//   ferr       held byte had its stop bit sampled low
//   ovr        sticky: a completed frame was dropped because full was set
//   busy       receiver is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] bitperiod,
  input  logic        rd,
  output logic [7:0]  data,
  output logic        full,
  output logic        ferr,
  output logic        ovr,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state;
  logic        prev_rxd;   // previous rxd, used for falling-edge detection
  logic [15:0] cnt;        // down-counter to the next sample instant
  logic [15:0] period;     // bit period latched for the current frame
  logic [2:0]  bit_idx;    // data bit being received
  logic [7:0]  shreg;      // data bits shift in from the MSB end (LSB first)

  // Clamped divisor; the half-period must be at least 2 so the first
  // interval (H-1) never underflows.
  logic [15:0] p_clamp;
  assign p_clamp = (bitperiod < 16'd4) ? 16'd4 : bitperiod;

  // A frame completes on the stop-sample cycle. It is accepted when the holding
  // register is empty or is being read in that same cycle; a coincident read
  // loses to the load.
  logic load_ok;
  assign load_ok = !full || rd;

  // NOTE: every register below is assigned with non-blocking (<=) so that all
  // of them see the pre-edge values; later assignments in the block override
  // earlier defaults for the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prev_rxd <= 1'b1;
      cnt      <= 16'd0;
      period   <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      data     <= 8'h00;
      full     <= 1'b0;
      ferr     <= 1'b0;
      ovr      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      prev_rxd <= rxd;

      // Acknowledge; a stop-cycle load further down takes priority.
      if (rd) begin
        full <= 1'b0;
        ferr <= 1'b0;
        ovr  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (prev_rxd && !rxd) begin
            period <= p_clamp;
            cnt    <= (p_clamp >> 1) - 16'd1;
            state  <= START;
            busy   <= 1'b1;
          end
        end

        START: begin
          if (cnt == 16'd0) begin
            if (rxd) begin
              // Line was high again at mid-start-bit: glitch, not a frame.
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
              cnt     <= period - 16'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        DATA: begin
          if (cnt == 16'd0) begin
            shreg <= {rxd, shreg[7:1]};
            cnt   <= period - 16'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        STOP: begin
          if (cnt == 16'd0) begin
            if (load_ok) begin
              data <= shreg;
              full <= 1'b1;
              ferr <= !rxd;
            end else begin
              ovr <= 1'b1;
            end
            // A low stop bit means the line may be held in break; wait for
            // it to return high before looking for another start edge.
            state <= rxd ? IDLE : BREAK;
            busy  <= !rxd;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        BREAK: begin
          if (rxd) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the `cdc` synchronizer and consumes its glitch-filtered `y` output as `rxd`. It detects start bits, samples 8N1 frames at mid-bit using a runtime bit-period divisor, and presents each byte in a one-deep holding register with full, framing-error and overrun flags. It is the receive path feeding the CPU's I/O port.

## Interface
- No parameters; frame format is fixed at 8 data bits, no parity, 1 stop bit, LSB first.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous active-high reset.
- `rxd` input 1: serial data, already synchronized (idle high).
- `bitperiod` input 16: clocks per bit, P. Latched at start-bit detection. Values below 4 are treated as 4.
- `rd` input 1: one-cycle pulse that acknowledges the held byte and clears `full`, `ferr` and `ovr`.
- `data` output 8: held byte.
- `full` output 1: the holding register contains an unread byte.
- `ferr` output 1: framing error for the held byte (stop bit sampled low).
- `ovr` output 1: sticky flag; a completed frame was dropped because `full` was set.
- `busy` output 1: the receiver is not in IDLE.

## Operation
- **Reset values:**
  - `data=0x00`, `full=0`, `ferr=0`, `ovr=0`, `busy=0`.
  - State is IDLE, and the previous-`rxd` register is 1.
  - Assertion of `rst` mid-frame aborts the frame immediately.
- **States:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:**
  - The falling edge (previous `rxd`=1, current `rxd`=0) is time t0. It latches P (clamped to at least 4) and H = P>>1, then enters START.
- **START:**
  - At t0+H, sample `rxd`.
  - If 1, the event is a false start: return to IDLE with no flag change.
  - If 0, enter DATA with bit index 0.
- **DATA:**
  - Bit i (0..7) is sampled at t0+H+(i+1)·P and shifted in LSB first.
  - After bit 7, enter STOP.
- **STOP:**
  - Stop bit is sampled at t0+H+9·P.
  - If `full`=0 or `rd`=1 in that cycle: load `data`, set `full`, and set `ferr` to the inverse of the stop sample.
  - Otherwise, `data` and `ferr` are unchanged, `ovr` is set, and the byte is discarded.
  - Next state: IDLE if the stop sample is 1; BREAK if it is 0.
- **BREAK:**
  - Wait for `rxd`=1, then go to IDLE.
  - The previous-`rxd` register tracks continuously, so a new start requires a fresh 1→0 edge.
- **`rd` handling:**
  - `rd` with `full`=0 still clears `ovr` and `ferr`.
  - `rd` coincident with a STOP load: the load wins. `full` stays 1, new `data` and `ferr` are loaded, and `ovr` is cleared (not set).
- **Counter:**
  - 16-bit down-counter, reloaded with P-1 at each sample.
  - The first interval is H-1, counted from the t0 cycle.

## Timing
- Sample instants are the rising edges listed above. `data`/`full`/`ferr`/`ovr` update on the edge after the stop sample, so they are visible at t0+H+9·P+1.
- `busy` goes high the cycle after t0. It goes low the cycle after the STOP→IDLE transition, or after BREAK exits, or after a false start.
- `rd` takes effect on the next edge; flags read 0 the following cycle.
- End-to-end latency from a physical start edge adds the `cdc` delay of 3–4 clocks upstream. Error budget is ±H/P of a bit, so P≥16 is recommended for ±3% baud mismatch.
- Back-to-back frames: a new start edge is accepted any cycle after returning to IDLE, including the cycle right after STOP.

## Test plan
- **Basic frame:** P=16, send 0x55 with a valid stop, t0 = edge cycle.
  - `full`=1, `data`=0x55, `ferr`=0 first visible at t0+153.
  - `busy`=0 by t0+154.
- **False start:** P=16, `rxd` low for 5 cycles then high.
  - No load; `full`=0.
  - `busy` returns to 0 by t0+9.
- **Break:** P=16, `rxd` held low for 40 bit periods.
  - Exactly one load: `data`=0x00, `ferr`=1.
  - No further frames while low.
  - After `rxd` goes high, a subsequent 0xA5 frame is received correctly.
- **Overrun:** send 0xA3 then 0x5C with no `rd`.
  - `data`=0xA3 and `ovr`=1.
  - After an `rd` pulse: `full`=0, `ovr`=0, `ferr`=0.
- **Simultaneous read and load:** `full`=1 holding 0x11; pulse `rd` exactly in the stop-sample cycle of frame 0x22.
  - `full`=1, `data`=0x22, `ovr`=0.
- **Reset mid-frame:** assert `rst` during DATA bit 4 of 0xFF.
  - All outputs read 0 at once, with no load.
  - After deassert, a clean 0x3C frame (P=4) yields `data`=0x3C.
